pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
Parametrised program-counter unit for the IF stage. It extends a plain PC register with several additions: reset and trap vectors, prioritised redirect selection, and a valid/ready request handshake toward instruction memory. A redirect that arrives while fetch is stalled is held in a pending register and applied later, and misaligned control-flow targets are detected. It sits between the EX/branch-resolution and trap logic and the instruction ROM address port.

Parameters:
XLEN, 32, PC and target width in bits (>=8)
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
TRAP_VECTOR, 32'h0000_0100, PC value loaded on trap or misaligned target
INC, 4, sequential increment in bytes (power of 2, 2 or 4)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
stall  input  1  hazard stall from the pipeline; blocks PC advance
trap  input  1  trap request, highest priority
jump  input  1  jump (JAL/JALR) redirect request
jump_target  input  XLEN  jump destination
branch_taken  input  1  taken-branch redirect request
branch_target  input  XLEN  branch destination
imem_req_ready  input  1  instruction memory accepts the address this cycle
imem_req_valid  output  1  PC is a valid fetch request
pc  output  XLEN  current fetch address
pc_plus_inc  output  XLEN  pc + INC (combinational)
flush  output  1  one-cycle pulse: IF/ID contents are wrong-path
misalign_exc  output  1  one-cycle pulse: redirect target was misaligned
bad_addr  output  XLEN  offending target of the last misalign_exc
pend_valid  output  1  a redirect is held pending

Behaviour:
- Reset (async, any time, including mid-stall or with a redirect pending): pc=RESET_VECTOR, imem_req_valid=0, pend_valid=0, flush=0, misalign_exc=0, bad_addr=0. imem_req_valid rises to 1 on the first clk edge after reset deasserts and stays 1 until the next reset.
- adv = imem_req_valid & imem_req_ready & ~stall.
- Live redirect selection (combinational), priority trap > jump > branch_taken:
  - trap selects TRAP_VECTOR.
  - jump selects jump_target.
  - branch_taken selects branch_target.
  - A selected jump or branch target with target % INC != 0 becomes TRAP_VECTOR and is marked misaligned.
- Each rising edge, in priority order:
  1. Live redirect and adv: pc <= live target; pend_valid cleared.
  2. Live redirect and !adv: captured into pending (target plus trap flag). An existing pending trap is overwritten only by another trap. Otherwise the newest redirect overwrites the pending one. pc is unchanged.
  3. No live redirect, pend_valid, adv: pc <= pending target; pend_valid <= 0.
  4. No redirect of any kind, adv: pc <= pc + INC, with modulo 2^XLEN wrap (all-ones region wraps to 0).
  5. Otherwise pc holds.
- flush is registered. It is 1 in the cycle after any edge where a redirect (live or pending) was captured or applied to pc; otherwise it is 0. Back-to-back redirects keep flush high.
- misalign_exc is registered. It is 1 for exactly one cycle after the edge where a misaligned live redirect was selected; bad_addr is loaded with the raw target on that edge. A pending entry produces no second misalign pulse when it is applied.
- imem_req_valid is not dropped by stall. The memory may see the same pc on consecutive cycles.
- pc_plus_inc = pc + INC truncated to XLEN.
- Latency: a redirect seen at edge N with adv=1 is visible on pc after edge N. A redirect with adv=0 becomes visible after the first later edge with adv=1.

Test Plan:
- Reset then run: reset high 3 cycles, release, ready=1, stall=0 -> pc 0,0 during reset; imem_req_valid 1 after first edge; pc 0,4,8,C on successive edges.
- Stall and backpressure: at pc=0x10, stall=1 for 2 cycles, then ready=0 for 1 cycle -> pc stays 0x10 for 3 cycles, then 0x14.
- Priority: trap=1, jump=1 (0x200), branch_taken=1 (0x300) in one adv cycle -> pc=0x100, flush=1 next cycle, misalign_exc=0.
- Pending redirect: stall=1, branch_taken to 0x40 for one cycle, then jump to 0x80 while still stalled, then stall=0 -> pend_valid=1; pc=0x80 after release edge; flush pulses; pend_valid=0.
- Misaligned target: jump_target=0x22 (INC=4) with adv -> pc=0x100, misalign_exc=1 one cycle, bad_addr=0x22.
- Wrap and reset mid-pending: pc=0xFFFF_FFFC, advance -> pc=0. Capture a pending trap, assert reset async mid-cycle -> pc=0 immediately, pend_valid=0.

Source files
------------

// File: rtl/pc_unit.sv
// Program-counter unit for the IF stage: reset/trap vectors, prioritised redirects,
// a pending-redirect register for stalled fetch, and misaligned-target detection.
module pc_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'('h100),
  parameter int              INC          = 4
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_stall,
  input  logic            i_trap,
  input  logic            i_jump,
  input  logic [XLEN-1:0] i_jump_target,
  input  logic            i_branch_taken,
  input  logic [XLEN-1:0] i_branch_target,
  input  logic            i_imem_req_ready,
  output logic            o_imem_req_valid,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_plus_inc,
  output logic            o_flush,
  output logic            o_misalign_exc,
  output logic [XLEN-1:0] o_bad_addr,
  output logic            o_pend_valid
);

  localparam logic [XLEN-1:0] INC_VAL  = XLEN'(INC);
  localparam logic [XLEN-1:0] LOW_MASK = XLEN'(INC - 1);

  logic [XLEN-1:0] r_pc;
  logic            r_reqValid;
  logic            r_flush;
  logic            r_misalign;
  logic [XLEN-1:0] r_badAddr;
  logic            r_pendValid;
  logic            r_pendTrap;
  logic [XLEN-1:0] r_pendTarget;

  logic            w_adv;
  logic            w_live;
  logic            w_liveMis;
  logic [XLEN-1:0] w_rawTarget;
  logic [XLEN-1:0] w_liveTarget;
  logic            w_keepPending;

  assign w_adv = r_reqValid & i_imem_req_ready & ~i_stall;

  always_comb begin
    w_live       = 1'b0;
    w_liveMis    = 1'b0;
    w_rawTarget  = '0;
    w_liveTarget = TRAP_VECTOR;
    if (i_trap) begin
      w_live = 1'b1;
    end else if (i_jump || i_branch_taken) begin
      w_live       = 1'b1;
      w_rawTarget  = i_jump ? i_jump_target : i_branch_target;
      w_liveMis    = (w_rawTarget & LOW_MASK) != '0;
      w_liveTarget = w_liveMis ? TRAP_VECTOR : w_rawTarget;
    end
  end

  // A held trap may only be displaced by another trap.
  assign w_keepPending = r_pendValid & r_pendTrap & ~i_trap;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pc         <= RESET_VECTOR;
      r_reqValid   <= 1'b0;
      r_flush      <= 1'b0;
      r_misalign   <= 1'b0;
      r_badAddr    <= '0;
      r_pendValid  <= 1'b0;
      r_pendTrap   <= 1'b0;
      r_pendTarget <= '0;
    end else begin
      r_reqValid <= 1'b1;
      r_flush    <= w_live | (r_pendValid & w_adv);
      r_misalign <= w_liveMis;
      if (w_liveMis) begin
        r_badAddr <= w_rawTarget;
      end
      if (w_live && w_adv) begin
        r_pc        <= w_liveTarget;
        r_pendValid <= 1'b0;
      end else if (w_live) begin
        if (!w_keepPending) begin
          r_pendValid  <= 1'b1;
          r_pendTrap   <= i_trap;
          r_pendTarget <= w_liveTarget;
        end
      end else if (r_pendValid && w_adv) begin
        r_pc        <= r_pendTarget;
        r_pendValid <= 1'b0;
      end else if (w_adv) begin
        r_pc <= r_pc + INC_VAL;
      end
    end
  end

  assign o_pc             = r_pc;
  assign o_pc_plus_inc    = r_pc + INC_VAL;
  assign o_imem_req_valid = r_reqValid;
  assign o_flush          = r_flush;
  assign o_misalign_exc   = r_misalign;
  assign o_bad_addr       = r_badAddr;
  assign o_pend_valid     = r_pendValid;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios plus randomized stimulus against a
// behavioural model of the redirect/advance rules.
module tb_pc_unit;

  localparam int          XLEN = 32;
  localparam logic [31:0] RV   = 32'h0000_0000;
  localparam logic [31:0] TV   = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        trap = 1'b0;
  logic        jump = 1'b0;
  logic [31:0] jumpTarget = '0;
  logic        branchTaken = 1'b0;
  logic [31:0] branchTarget = '0;
  logic        ready = 1'b1;
  logic        reqValid;
  logic [31:0] pc;
  logic [31:0] pcPlusInc;
  logic        flush;
  logic        misalignExc;
  logic [31:0] badAddr;
  logic        pendValid;

  int total = 0;
  int bad = 0;

  logic [31:0] mPc;
  logic        mValid, mFlush, mMis, mPendValid, mPendTrap;
  logic [31:0] mBad, mPendTarget;

  pc_unit #(.XLEN(XLEN), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .INC(4)) dut (
    .i_clk(clk), .i_reset(reset), .i_stall(stall), .i_trap(trap),
    .i_jump(jump), .i_jump_target(jumpTarget),
    .i_branch_taken(branchTaken), .i_branch_target(branchTarget),
    .i_imem_req_ready(ready), .o_imem_req_valid(reqValid), .o_pc(pc),
    .o_pc_plus_inc(pcPlusInc), .o_flush(flush), .o_misalign_exc(misalignExc),
    .o_bad_addr(badAddr), .o_pend_valid(pendValid)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mPc = RV; mValid = 0; mFlush = 0; mMis = 0; mBad = 0;
    mPendValid = 0; mPendTrap = 0; mPendTarget = 0;
  endtask

  // Next state from the rules: priority trap > jump > branch, misaligned -> trap vector.
  task automatic modelStep();
    logic adv, live, mis;
    logic [31:0] raw, tgt;
    adv = mValid && ready && !stall;
    live = trap || jump || branchTaken;
    mis = 0; raw = 0; tgt = TV;
    if (!trap && (jump || branchTaken)) begin
      raw = jump ? jumpTarget : branchTarget;
      mis = (raw % 4) != 0;
      tgt = mis ? TV : raw;
    end
    mFlush = live || (mPendValid && adv);
    mMis = mis;
    if (mis) mBad = raw;
    if (live && adv) begin
      mPc = tgt; mPendValid = 0;
    end else if (live) begin
      if (!(mPendValid && mPendTrap && !trap)) begin
        mPendValid = 1; mPendTrap = trap; mPendTarget = tgt;
      end
    end else if (mPendValid && adv) begin
      mPc = mPendTarget; mPendValid = 0;
    end else if (adv) begin
      mPc = mPc + 32'd4;
    end
    mValid = 1;
  endtask

  task automatic checkAll();
    checkOutput("pc", pc, mPc);
    checkOutput("pc_plus_inc", pcPlusInc, mPc + 32'd4);
    checkOutput("imem_req_valid", {31'b0, reqValid}, {31'b0, mValid});
    checkOutput("flush", {31'b0, flush}, {31'b0, mFlush});
    checkOutput("misalign_exc", {31'b0, misalignExc}, {31'b0, mMis});
    checkOutput("bad_addr", badAddr, mBad);
    checkOutput("pend_valid", {31'b0, pendValid}, {31'b0, mPendValid});
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
    checkAll();
  endtask

  task automatic applyStimulus(input logic s, input logic r, input logic t,
                               input logic j, input logic [31:0] jt,
                               input logic b, input logic [31:0] bt);
    stall = s; ready = r; trap = t; jump = j; jumpTarget = jt;
    branchTaken = b; branchTarget = bt;
    tick();
  endtask

  task automatic idle();
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [31:0] expSeq [4];
    expSeq = '{32'h0, 32'h4, 32'h8, 32'hC};

    // Reset held three cycles
    modelReset();
    reset = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      checkOutput("reset_pc", pc, RV);
      checkOutput("reset_valid", {31'b0, reqValid}, 32'd0);
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idle();
      checkOutput("run_pc", pc, expSeq[i]);
    end
    checkOutput("run_valid", {31'b0, reqValid}, 32'd1);

    // Stall and backpressure at 0x10
    applyStimulus(0, 1, 0, 1, 32'h10, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    checkOutput("stall1_pc", pc, 32'h10);
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    checkOutput("stall2_pc", pc, 32'h10);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("notready_pc", pc, 32'h10);
    idle();
    checkOutput("resume_pc", pc, 32'h14);

    // Priority trap > jump > branch
    applyStimulus(0, 1, 1, 1, 32'h200, 1, 32'h300);
    checkOutput("prio_pc", pc, 32'h100);
    checkOutput("prio_flush", {31'b0, flush}, 32'd1);
    checkOutput("prio_mis", {31'b0, misalignExc}, 32'd0);

    // Pending redirect while stalled; newest overwrites
    applyStimulus(1, 1, 0, 0, 0, 1, 32'h40);
    checkOutput("pend_set", {31'b0, pendValid}, 32'd1);
    applyStimulus(1, 1, 0, 1, 32'h80, 0, 0);
    idle();
    checkOutput("pend_pc", pc, 32'h80);
    checkOutput("pend_flush", {31'b0, flush}, 32'd1);
    checkOutput("pend_clear", {31'b0, pendValid}, 32'd0);
    idle();
    checkOutput("flush_drop", {31'b0, flush}, 32'd0);

    // Misaligned jump target
    applyStimulus(0, 1, 0, 1, 32'h22, 0, 0);
    checkOutput("mis_pc", pc, 32'h100);
    checkOutput("mis_pulse", {31'b0, misalignExc}, 32'd1);
    checkOutput("mis_bad", badAddr, 32'h22);
    idle();
    checkOutput("mis_drop", {31'b0, misalignExc}, 32'd0);

    // Wrap at top of address space
    applyStimulus(0, 1, 0, 1, 32'hFFFF_FFFC, 0, 0);
    checkOutput("wrap_top", pcPlusInc, 32'h0);
    idle();
    checkOutput("wrap_pc", pc, 32'h0);

    // Pending trap, then asynchronous reset mid-cycle
    applyStimulus(1, 1, 1, 0, 0, 0, 0);
    checkOutput("ptrap_set", {31'b0, pendValid}, 32'd1);
    #2 reset = 1'b1;
    #1;
    modelReset();
    checkOutput("async_pc", pc, RV);
    checkOutput("async_pend", {31'b0, pendValid}, 32'd0);
    checkOutput("async_valid", {31'b0, reqValid}, 32'd0);
    stall = 0; trap = 0;
    @(negedge clk);
    reset = 1'b0;

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [31:0] jt, bt;
      jt = $urandom & ~32'h3;
      bt = $urandom & ~32'h3;
      if ($urandom_range(0, 3) == 0) jt = jt | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0) bt = bt | 32'($urandom_range(1, 3));
      applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0, jt,
                    $urandom_range(0, 9) == 0, bt);
      if (n == 200) begin
        #2 reset = 1'b1;
        #1;
        modelReset();
        checkAll();
        @(negedge clk);
        reset = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
